d_kes_dc_accumulator: RTL
=========================

// Module: d_KES_DC_accumulator
// PURPOSE
//  Consumer side of the KES discrepancy-computation PE array. Collects the o_coef_2ip1 products of
//  NUM_PE d_KES_PE_DC units, XOR-reduces them in GF(2^12) over a 2-stage pipeline into the
//  discrepancy delta_2i+1, and issues one valid pulse per SiBM iteration with an iteration count.
//  Sits between the PE_DC array and the KES control / PE_ELU update logic.
// PARAMETERS
//  NUM_PE    8   number of PE_DC coefficient inputs; NUM_PE % GROUP_SZ == 0
//  GROUP_SZ  4   coefficients XORed per stage-1 group; NUM_GRP = NUM_PE/GROUP_SZ
//  T_MAX     14  SiBM iterations per codeword; o_iter_last flags iteration T_MAX-1
//  CNT_W     4   iteration counter width; 2**CNT_W >= T_MAX
// PORTS
//  i_clk            in   1                       clock; all logic on rising edge
//  i_RESET_KES      in   1                       synchronous active-high reset
//  i_stop_dec       in   1                       synchronous abort; same effect as reset
//  i_EXECUTE_DC_ACC in   1                       same pulse that drives i_EXECUTE_PE_DC of the array
//  i_coef_bus       in   NUM_PE*`D_KES_GF_ORDER  PE k coef at [k*12 +: 12]
//  o_delta          out  `D_KES_GF_ORDER         XOR of all NUM_PE coefs of the last accepted iteration
//  o_delta_valid    out  1                       one-cycle pulse: o_delta updated this cycle
//  o_delta_nonzero  out  1                       o_delta != 0; qualified by o_delta_valid
//  o_iter_cnt       out  CNT_W                   index of the iteration o_delta belongs to
//  o_iter_last      out  1                       o_iter_cnt == T_MAX-1; qualified by o_delta_valid
//  o_busy           out  1                       iteration in flight; execute ignored while high
// BEHAVIOUR
//  - Reset / stop: state=IDLE, o_delta=0, o_delta_valid=0, o_delta_nonzero=0, o_iter_cnt=0,
//    o_iter_last=0, o_busy=0, pipeline registers=0. Asserted mid-iteration: pipeline flushed, no
//    valid pulse for the aborted iteration, counter back to 0. Reset wins over execute in same cycle.
//  - FSM (one-hot): IDLE -> CAPT -> RED1 -> RED2 -> IDLE.
//    IDLE: execute=1 sampled at edge ending cycle N -> CAPT. o_busy=1 from cycle N+1.
//    CAPT (cycle N+1): PE_DC registers hold operands; coef bus is valid. Edge ending N+1 latches
//      stage-1 partials P[g] = XOR of coefs g*GROUP_SZ .. g*GROUP_SZ+GROUP_SZ-1. -> RED1.
//    RED1 (cycle N+2): edge ending N+2 latches o_delta = XOR of P[0..NUM_GRP-1],
//      o_delta_nonzero = (that XOR != 0). -> RED2.
//    RED2 (cycle N+3): o_delta_valid=1, o_iter_last as defined, o_busy=0 in this cycle.
//      Edge ending N+3: o_iter_cnt increments; wraps to 0 after T_MAX-1. -> IDLE.
//  - Latency execute -> valid = 3 cycles; throughput one iteration per 4 cycles. Execute sampled in
//    RED2 is accepted (back-to-back issue: next valid at N+7).
//  - Execute high in CAPT/RED1: ignored, no error, no counter effect.
//  - GF add = bitwise XOR; no carries, width fixed at `D_KES_GF_ORDER.
//  - o_delta holds its value between valid pulses; o_iter_cnt holds between iterations.
//  - o_iter_cnt shown with valid is the pre-increment value (0 for the first iteration).
// CONFIGURATION
//  D_KES_DC_REG_OUT_EN defined: extra output register stage RED3 between RED2 and IDLE;
//    o_delta/o_delta_nonzero/o_iter_cnt/o_iter_last re-registered, o_delta_valid at N+4,
//    o_busy covers N+1..N+3, execute accepted from the RED3 cycle; counter increments at end of RED3.
//  Undefined: 3-cycle latency exactly as above.
// TESTING
//  1 Reset: hold i_RESET_KES 2 cycles, bus=all 0xFFF -> all outputs 0, no valid pulse.
//  2 Single iteration: coefs 0x001,0x002,0x004,...,0x080, execute at N -> valid only at N+3,
//    o_delta=0x0FF, nonzero=1, iter_cnt=0.
//  3 Cancellation: coefs 0xABC,0xABC, rest 0 -> o_delta=0x000, nonzero=0 with valid.
//  4 T_MAX run: 14 executes every 4 cycles -> iter_cnt 0..13, o_iter_last only with cnt=13,
//    15th iteration reports cnt=0.
//  5 Abort: execute at N, i_stop_dec at N+2 -> no valid at N+3, cnt=0, next execute works normally.
//  6 Busy/macro: execute at N and N+1 -> single valid at N+3; with D_KES_DC_REG_OUT_EN valid at N+4.

Source files
------------

// File: rtl/d_kes_dc_accumulator.sv
// KES discrepancy accumulator: 2-stage GF(2^m) XOR reduction of the PE_DC coefficient bus.
// Optional D_KES_DC_REG_OUT_EN adds an output register stage (RED3) before the valid pulse.

`ifndef D_KES_GF_ORDER
`define D_KES_GF_ORDER 12
`endif

module d_kes_dc_accumulator #(
    parameter int unsigned NUM_PE   = 8,
    parameter int unsigned GROUP_SZ = 4,
    parameter int unsigned T_MAX    = 14,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                              i_clk,
    input  logic                              i_RESET_KES,
    input  logic                              i_stop_dec,
    input  logic                              i_EXECUTE_DC_ACC,
    input  logic [NUM_PE*`D_KES_GF_ORDER-1:0] i_coef_bus,
    output logic [`D_KES_GF_ORDER-1:0]        o_delta,
    output logic                              o_delta_valid,
    output logic                              o_delta_nonzero,
    output logic [CNT_W-1:0]                  o_iter_cnt,
    output logic                              o_iter_last,
    output logic                              o_busy
);

    localparam int unsigned GF_W    = `D_KES_GF_ORDER;
    localparam int unsigned NUM_GRP = NUM_PE / GROUP_SZ;

`ifdef D_KES_DC_REG_OUT_EN
    localparam int unsigned NumSt = 5;
`else
    localparam int unsigned NumSt = 4;
`endif

    localparam logic [NumSt-1:0] StIdle = NumSt'(1);
    localparam logic [NumSt-1:0] StCapt = NumSt'(2);
    localparam logic [NumSt-1:0] StRed1 = NumSt'(4);
    localparam logic [NumSt-1:0] StRed2 = NumSt'(8);
`ifdef D_KES_DC_REG_OUT_EN
    localparam logic [NumSt-1:0] StRed3 = NumSt'(16);
    localparam logic [NumSt-1:0] StLast = StRed3;
`else
    localparam logic [NumSt-1:0] StLast = StRed2;
`endif

    logic [NumSt-1:0] state_q, state_d;
    logic             pend_q, pend_d;
    logic             clear;

    logic [NUM_GRP-1:0][GF_W-1:0] part_d, part_q;
    logic [GF_W-1:0]              sum_d;
    logic [GF_W-1:0]              delta_q;
    logic                         nz_q;
    logic [CNT_W-1:0]             cnt_q;

    assign clear = i_RESET_KES | i_stop_dec;

    // An execute seen in the final cycle is queued and launched from IDLE on the next edge,
    // so back-to-back iterations keep a fixed cadence.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (pend_q || i_EXECUTE_DC_ACC) begin
                    state_d = StCapt;
                    pend_d  = 1'b0;
                end
            end
            StCapt: state_d = StRed1;
            StRed1: state_d = StRed2;
`ifdef D_KES_DC_REG_OUT_EN
            StRed2: state_d = StRed3;
            StRed3: begin
                state_d = StIdle;
                pend_d  = i_EXECUTE_DC_ACC;
            end
`else
            StRed2: begin
                state_d = StIdle;
                pend_d  = i_EXECUTE_DC_ACC;
            end
`endif
            default: begin
                state_d = StIdle;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            state_q <= StIdle;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Stage 1: per-group XOR of GROUP_SZ coefficients.
    always_comb begin
        part_d = '0;
        for (int unsigned g = 0; g < NUM_GRP; g++) begin
            for (int unsigned k = 0; k < GROUP_SZ; k++) begin
                part_d[g] = part_d[g] ^ i_coef_bus[(g*GROUP_SZ + k)*GF_W +: GF_W];
            end
        end
    end

    // Stage 2: XOR of the group partials.
    always_comb begin
        sum_d = '0;
        for (int unsigned g = 0; g < NUM_GRP; g++) begin
            sum_d = sum_d ^ part_q[g];
        end
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            part_q <= '0;
        end else if (state_q == StCapt) begin
            part_q <= part_d;
        end
    end

`ifdef D_KES_DC_REG_OUT_EN
    logic [GF_W-1:0] delta_s2_q;
    logic            nz_s2_q;
    logic            last_q;

    always_ff @(posedge i_clk) begin
        if (clear) begin
            delta_s2_q <= '0;
            nz_s2_q    <= 1'b0;
            delta_q    <= '0;
            nz_q       <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (state_q == StRed1) begin
                delta_s2_q <= sum_d;
                nz_s2_q    <= |sum_d;
            end
            if (state_q == StRed2) begin
                delta_q <= delta_s2_q;
                nz_q    <= nz_s2_q;
                last_q  <= (cnt_q == CNT_W'(T_MAX - 1));
            end
        end
    end

    assign o_iter_last = o_delta_valid & last_q;
    assign o_busy      = (state_q == StCapt) | (state_q == StRed1) | (state_q == StRed2) |
                         ((state_q == StIdle) & pend_q);
`else
    always_ff @(posedge i_clk) begin
        if (clear) begin
            delta_q <= '0;
            nz_q    <= 1'b0;
        end else if (state_q == StRed1) begin
            delta_q <= sum_d;
            nz_q    <= |sum_d;
        end
    end

    assign o_iter_last = o_delta_valid & (cnt_q == CNT_W'(T_MAX - 1));
    assign o_busy      = (state_q == StCapt) | (state_q == StRed1) |
                         ((state_q == StIdle) & pend_q);
`endif

    // Iteration counter advances after the valid cycle, so the pulse shows the pre-increment value.
    always_ff @(posedge i_clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (state_q == StLast) begin
            if (cnt_q == CNT_W'(T_MAX - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_delta         = delta_q;
    assign o_delta_nonzero = nz_q;
    assign o_delta_valid   = (state_q == StLast);
    assign o_iter_cnt      = cnt_q;

endmodule
